// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP receive definitions.
// Holds the one-hot receive state encoding and the protocol constants used
// by the UDP receive path. No ports.
package eth_pkg;

    // One-hot receive states
    typedef enum logic [6:0] {
        IDLE     = 7'b000_0001,
        PREAMBLE = 7'b000_0010,
        ETH_HEAD = 7'b000_0100,
        IP_HEAD  = 7'b000_1000,
        UDP_HEAD = 7'b001_0000,
        RX_DATA  = 7'b010_0000,
        RX_END   = 7'b100_0000
    } rx_state_e;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hd5;

    localparam logic [47:0] MAC_BROADCAST   = 48'hff_ff_ff_ff_ff_ff;
    localparam logic [15:0] PREAMBLE_EXTRA  = 16'd6;   // 0x55 bytes after the first one
    localparam logic [15:0] ETH_HDR_LAST    = 16'd13;  // index of last Ethernet header byte
    localparam logic [15:0] UDP_HDR_LAST    = 16'd7;   // index of last UDP header byte
    localparam logic [15:0] UDP_HDR_BYTES   = 16'd8;

endpackage

// File: rtl/byte_packer.sv
// Byte-to-word packer.
// Packs a stream of bytes MSB-first into DATA_W-bit words and emits a word
// one cycle after the byte that fills it, or after the byte flagged last.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   byte_i          input byte
//   valid_i         byte_i is valid this cycle
//   last_i          byte_i is the final byte of the packet
//   flush_i         discard any partially packed word without emitting it
//   word_o          packed word, first byte in the MSBs, unused bytes zero
//   keep_o          byte-valid mask, MSB for the first byte
//   valid_o         one-cycle strobe, word_o/keep_o/last_o valid
//   last_o          word_o is the final word of the packet
module byte_packer #(
    parameter int DATA_W = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          byte_i,
    input  logic                valid_i,
    input  logic                last_i,
    input  logic                flush_i,
    output logic [DATA_W-1:0]   word_o,
    output logic [DATA_W/8-1:0] keep_o,
    output logic                valid_o,
    output logic                last_o
);

    localparam int NB = DATA_W / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [NB-1:0]     acck_q, acck_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [NB-1:0]     keep_q, keep_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] ins_word;
    logic [NB-1:0]     ins_keep;

    always_comb begin
        idx_d    = idx_q;
        acc_d    = acc_q;
        acck_d   = acck_q;
        word_d   = word_q;
        keep_d   = keep_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        ins_word = acc_q;
        ins_keep = acck_q;

        // Accumulator with the incoming byte dropped into its slot
        for (int i = 0; i < NB; i++) begin
            if (idx_q == IW'(i)) begin
                ins_word[DATA_W-1-8*i -: 8] = byte_i;
                ins_keep[NB-1-i]            = 1'b1;
            end
        end

        if (flush_i) begin
            idx_d  = '0;
            acc_d  = '0;
            acck_d = '0;
        end else if (valid_i) begin
            if (last_i || idx_q == IW'(NB-1)) begin
                word_d  = ins_word;
                keep_d  = ins_keep;
                valid_d = 1'b1;
                last_d  = last_i;
                idx_d   = '0;
                acc_d   = '0;
                acck_d  = '0;
            end else begin
                idx_d  = idx_q + 1'b1;
                acc_d  = ins_word;
                acck_d = ins_keep;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            acc_q   <= '0;
            acck_q  <= '0;
            word_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            acck_q  <= acck_d;
            word_q  <= word_d;
            keep_q  <= keep_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign word_o  = word_q;
    assign keep_o  = keep_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: rtl/udp_rx_wide.sv
// GMII UDP receiver with a wide payload output.
// Parses preamble, Ethernet, IPv4 and UDP headers from a GMII byte stream,
// filters on MAC/IP/port, and delivers the UDP payload as DATA_W-bit words.
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   gmii_rx_dv, gmii_rxd    GMII receive valid and byte
//   rec_en                  one-cycle strobe, rec_data/rec_keep/rec_last valid
//   rec_data, rec_keep      payload word (first byte in MSBs) and byte mask
//   rec_last                final payload word of a packet
//   rec_pkt_done            one-cycle strobe when a good packet completes
//   rec_byte_num            payload length of the last good packet
//   rec_err                 one-cycle strobe when a frame is dropped
//   drop_cnt                saturating dropped-frame count
//
// state    | meaning
// IDLE     | waiting for the first 0x55 with rx_dv high
// PREAMBLE | counting six more 0x55 bytes, then the 0xd5 SFD
// ETH_HEAD | 14-byte MAC header: destination MAC and EtherType checks
// IP_HEAD  | IPv4 header: version, IHL, protocol, destination IP checks
// UDP_HEAD | 8-byte UDP header: port and length capture and checks
// RX_DATA  | payload bytes fed to the packer
// RX_END   | ignore the rest of the frame until rx_dv drops
module udp_rx_wide
    import eth_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC      = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] BOARD_IP       = 32'h0,
    parameter logic [15:0] BOARD_PORT     = 16'd1234,
    parameter bit          PORT_FILTER_EN = 1'b1,
    parameter int          DATA_W         = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                gmii_rx_dv,
    input  logic [7:0]          gmii_rxd,
    output logic                rec_en,
    output logic [DATA_W-1:0]   rec_data,
    output logic [DATA_W/8-1:0] rec_keep,
    output logic                rec_last,
    output logic                rec_pkt_done,
    output logic [15:0]         rec_byte_num,
    output logic                rec_err,
    output logic [15:0]         drop_cnt
);

    rx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [47:0] mac_q, mac_d;
    logic [7:0]  type_hi_q, type_hi_d;
    logic [5:0]  ip_hlen_q, ip_hlen_d;
    logic [15:0] port_q, port_d;
    logic [15:0] ulen_q, ulen_d;
    logic [15:0] pay_len_q, pay_len_d;
    logic        pkt_done_q, pkt_done_d;
    logic [15:0] byte_num_q, byte_num_d;
    logic        err_q, err_d;
    logic [15:0] drop_q, drop_d;

    logic        pk_valid, pk_last, pk_flush;
    logic        err_now;
    logic [7:0]  ip_byte;

    // Expected destination-IP octet for header bytes 16..19
    always_comb begin
        ip_byte = BOARD_IP[31:24];
        case (cnt_q[1:0])
            2'd0:    ip_byte = BOARD_IP[31:24];
            2'd1:    ip_byte = BOARD_IP[23:16];
            2'd2:    ip_byte = BOARD_IP[15:8];
            default: ip_byte = BOARD_IP[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mac_d      = mac_q;
        type_hi_d  = type_hi_q;
        ip_hlen_d  = ip_hlen_q;
        port_d     = port_q;
        ulen_d     = ulen_q;
        pay_len_d  = pay_len_q;
        pkt_done_d = 1'b0;
        byte_num_d = byte_num_q;
        err_d      = 1'b0;
        drop_d     = drop_q;
        pk_valid   = 1'b0;
        pk_last    = 1'b0;
        pk_flush   = 1'b0;
        err_now    = 1'b0;

        case (state_q)
            IDLE: begin
                if (gmii_rx_dv && gmii_rxd == PREAMBLE_BYTE) begin
                    state_d = PREAMBLE;
                    cnt_d   = '0;
                end
            end
            RX_END: begin
                if (!gmii_rx_dv) state_d = IDLE;
            end
            default: begin
                if (!gmii_rx_dv) begin
                    // Frame truncated: drop any partial word, keep words already sent
                    err_now  = 1'b1;
                    pk_flush = 1'b1;
                end else begin
                    case (state_q)
                        PREAMBLE: begin
                            if (cnt_q < PREAMBLE_EXTRA) begin
                                if (gmii_rxd == PREAMBLE_BYTE) cnt_d = cnt_q + 16'd1;
                                else                           err_now = 1'b1;
                            end else if (gmii_rxd == SFD_BYTE) begin
                                state_d = ETH_HEAD;
                                cnt_d   = '0;
                            end else begin
                                err_now = 1'b1;
                            end
                        end
                        ETH_HEAD: begin
                            cnt_d = cnt_q + 16'd1;
                            if (cnt_q < 16'd6)  mac_d     = {mac_q[39:0], gmii_rxd};
                            if (cnt_q == 16'd12) type_hi_d = gmii_rxd;
                            if (cnt_q == ETH_HDR_LAST) begin
                                if ((mac_q == BOARD_MAC || mac_q == MAC_BROADCAST) &&
                                    {type_hi_q, gmii_rxd} == ETH_TYPE_IPV4) begin
                                    state_d = IP_HEAD;
                                    cnt_d   = '0;
                                end else begin
                                    err_now = 1'b1;
                                end
                            end
                        end
                        IP_HEAD: begin
                            cnt_d = cnt_q + 16'd1;
                            if (cnt_q == 16'd0) begin
                                ip_hlen_d = {gmii_rxd[3:0], 2'b00};
                                if (gmii_rxd[7:4] != 4'd4 || gmii_rxd[3:0] < 4'd5) err_now = 1'b1;
                            end
                            if (cnt_q == 16'd9 && gmii_rxd != IP_PROTO_UDP) err_now = 1'b1;
                            if (cnt_q >= 16'd16 && cnt_q <= 16'd19 && gmii_rxd != ip_byte) err_now = 1'b1;
                            // Options (IHL > 5) are skipped by counting to the header length
                            if (cnt_q >= 16'd19 && cnt_q == {10'd0, ip_hlen_q} - 16'd1) begin
                                state_d = UDP_HEAD;
                                cnt_d   = '0;
                            end
                        end
                        UDP_HEAD: begin
                            cnt_d = cnt_q + 16'd1;
                            case (cnt_q)
                                16'd2:   port_d[15:8] = gmii_rxd;
                                16'd3:   port_d[7:0]  = gmii_rxd;
                                16'd4:   ulen_d[15:8] = gmii_rxd;
                                16'd5:   ulen_d[7:0]  = gmii_rxd;
                                default: ;
                            endcase
                            if (cnt_q == UDP_HDR_LAST) begin
                                if (ulen_q < UDP_HDR_BYTES) begin
                                    err_now = 1'b1;
                                end else if (PORT_FILTER_EN && port_q != BOARD_PORT) begin
                                    err_now = 1'b1;
                                end else if (ulen_q == UDP_HDR_BYTES) begin
                                    pkt_done_d = 1'b1;
                                    byte_num_d = '0;
                                    state_d    = RX_END;
                                end else begin
                                    pay_len_d = ulen_q - UDP_HDR_BYTES;
                                    state_d   = RX_DATA;
                                    cnt_d     = '0;
                                end
                            end
                        end
                        RX_DATA: begin
                            pk_valid = 1'b1;
                            if (cnt_q == pay_len_q - 16'd1) begin
                                // Registered alongside the packer's final word
                                pk_last    = 1'b1;
                                pkt_done_d = 1'b1;
                                byte_num_d = pay_len_q;
                                state_d    = RX_END;
                            end else begin
                                cnt_d = cnt_q + 16'd1;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase

        if (err_now) begin
            err_d = 1'b1;
            if (drop_q != 16'hffff) drop_d = drop_q + 16'd1;
            // With rx_dv already low the frame is over, so skip straight past RX_END
            state_d = gmii_rx_dv ? RX_END : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mac_q      <= '0;
            type_hi_q  <= '0;
            ip_hlen_q  <= '0;
            port_q     <= '0;
            ulen_q     <= '0;
            pay_len_q  <= '0;
            pkt_done_q <= 1'b0;
            byte_num_q <= '0;
            err_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mac_q      <= mac_d;
            type_hi_q  <= type_hi_d;
            ip_hlen_q  <= ip_hlen_d;
            port_q     <= port_d;
            ulen_q     <= ulen_d;
            pay_len_q  <= pay_len_d;
            pkt_done_q <= pkt_done_d;
            byte_num_q <= byte_num_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
        end
    end

    byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .byte_i  (gmii_rxd),
        .valid_i (pk_valid),
        .last_i  (pk_last),
        .flush_i (pk_flush),
        .word_o  (rec_data),
        .keep_o  (rec_keep),
        .valid_o (rec_en),
        .last_o  (rec_last)
    );

    assign rec_pkt_done = pkt_done_q;
    assign rec_byte_num = byte_num_q;
    assign rec_err      = err_q;
    assign drop_cnt     = drop_q;

endmodule
